// File: rtl/histo_pkg.sv
// Shared definitions for the histogram readout path: FSM encoding and
// default geometry used by histogram2, the readout sequencer and the serializer.
package histo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_ADDR,
      ST_CAPTURE,
      ST_SEND,
      ST_TRAILER
   } state_e;

   localparam int unsigned NUM_BINS_DEF = 1024;
   localparam int unsigned DATA_W_DEF   = 24;
   localparam logic [7:0]  HDR_MARK_DEF = 8'hA5;

endpackage

// File: rtl/histo_readout_ctrl_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse when x_i goes 0 -> 1.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic x_i,
   output logic rise_o
);

   logic x_q;

   // Remember the previous sample of the input.
   always_ff @(posedge clk) begin
      if (rst) x_q <= 1'b0;
      else     x_q <= x_i;
   end

   assign rise_o = x_i & ~x_q;

endmodule

// File: rtl/histo_readout_ctrl.sv
// Readout sequencer: after a completed histogram, walks every bin and streams
// header, bin counts and checksum trailer to the serializer over valid/ready.
module histo_readout_ctrl
   import histo_pkg::*;
#(
   parameter int unsigned NUM_BINS   = NUM_BINS_DEF,
   parameter int unsigned BIN_W      = 10,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned READ_LAT   = 1,
   parameter int unsigned FRAME_ID_W = 8,
   parameter logic [7:0]  HDR_MARK   = HDR_MARK_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fsin,
   input  logic                  histo_done,
   output logic                  histo_rw,
   output logic [BIN_W-1:0]      histo_bin,
   input  logic [DATA_W-1:0]     histo_data,
   output logic [DATA_W-1:0]     tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [FRAME_ID_W-1:0] frame_id,
   output logic                  busy,
   output logic                  overrun
);

   localparam int unsigned LAT_W = $clog2(READ_LAT + 1);
   // Header layout is marker, frame id, then zero padding in the low bits.
   localparam int unsigned PAD_W = DATA_W - 8 - FRAME_ID_W;

   state_e                state_q, state_d;
   logic [BIN_W-1:0]      bin_q, bin_d;
   logic                  rw_q, rw_d;
   logic [DATA_W-1:0]     tx_data_q, tx_data_d;
   logic [DATA_W-1:0]     csum_q, csum_d;
   logic [FRAME_ID_W-1:0] fid_q, fid_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic                  ovr_q, ovr_d;

   logic rise_fsin, rise_done, xfer;

   rise_detect u_rise_fsin (
      .clk    (clk),
      .rst    (rst),
      .x_i    (fsin),
      .rise_o (rise_fsin)
   );

   rise_detect u_rise_done (
      .clk    (clk),
      .rst    (rst),
      .x_i    (histo_done),
      .rise_o (rise_done)
   );

   // Valid comes only from registered state, never from tx_ready.
   assign tx_valid  = (state_q == ST_HEADER) || (state_q == ST_SEND) || (state_q == ST_TRAILER);
   assign xfer      = tx_valid & tx_ready;
   assign busy      = (state_q != ST_IDLE);
   assign histo_rw  = rw_q;
   assign histo_bin = bin_q;
   assign tx_data   = tx_data_q;
   assign frame_id  = fid_q;
   assign overrun   = ovr_q;

   // Next-state and datapath update for the readout sequence.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      rw_d      = rw_q;
      tx_data_d = tx_data_q;
      csum_d    = csum_q;
      fid_d     = fid_q;
      lat_d     = lat_q;
      // A new frame or histogram arriving mid-readout is flagged, not acted on.
      ovr_d     = ovr_q | (busy & (rise_fsin | rise_done));
      unique case (state_q)
         ST_IDLE: begin
            if (rise_done) begin
               csum_d    = '0;
               bin_d     = '0;
               rw_d      = 1'b0;
               lat_d     = '0;
               tx_data_d = {HDR_MARK, fid_q, {PAD_W{1'b0}}};
               state_d   = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (xfer) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            // Hold the address until the histogram read data has settled.
            if (lat_q == LAT_W'(READ_LAT - 1)) begin
               lat_d   = '0;
               state_d = ST_CAPTURE;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         ST_CAPTURE: begin
            tx_data_d = histo_data;
            csum_d    = csum_q + histo_data;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            if (xfer) begin
               if (bin_q == BIN_W'(NUM_BINS - 1)) begin
                  // Checksum already includes the last bin from CAPTURE.
                  tx_data_d = csum_q;
                  state_d   = ST_TRAILER;
               end else begin
                  bin_d   = bin_q + BIN_W'(1);
                  state_d = ST_ADDR;
               end
            end
         end
         ST_TRAILER: begin
            if (xfer) begin
               fid_d   = fid_q + FRAME_ID_W'(1);
               rw_d    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any readout in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bin_q     <= '0;
         rw_q      <= 1'b1;
         tx_data_q <= '0;
         csum_q    <= '0;
         fid_q     <= '0;
         lat_q     <= '0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         rw_q      <= rw_d;
         tx_data_q <= tx_data_d;
         csum_q    <= csum_d;
         fid_q     <= fid_d;
         lat_q     <= lat_d;
         ovr_q     <= ovr_d;
      end
   end

endmodule
